// File: rtl/cct_sequencer.sv
// Test-sequencing controller: clears the student circuit, streams an arithmetic
// progression into it, drains its pipeline and folds every output into a rotate-XOR signature.
// Optional self-compare output enabled by defining CCT_SEQ_COMPARE_EN.
module cct_sequencer #(
  parameter int WIDTH       = 8,
  parameter int NUM_VECTORS = 16,
  parameter int LATENCY     = 2
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             start,
  input  logic [WIDTH-1:0] seed,
  input  logic [WIDTH-1:0] step,
  output logic             busy,
  output logic             done,
  output logic             dut_clear,
  output logic [WIDTH-1:0] dut_input,
  input  logic [WIDTH-1:0] dut_output,
  output logic [WIDTH-1:0] signature,
  output logic [7:0]       vec_count
`ifdef CCT_SEQ_COMPARE_EN
  ,
  input  logic [WIDTH-1:0] expected_sig,
  output logic             pass
`endif
);

  typedef enum logic [2:0] {IDLE, CLEAR, DRIVE, DRAIN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] seed_l, step_l;
  logic [3:0]       drain_cnt;
  logic             last_vec, last_drain;

  function automatic logic [WIDTH-1:0] sig_fold(input logic [WIDTH-1:0] sig,
                                                input logic [WIDTH-1:0] obs);
    return {sig[WIDTH-2:0], sig[WIDTH-1]} ^ obs;
  endfunction

  assign last_vec   = (vec_count == 8'(NUM_VECTORS - 1));
  assign last_drain = (drain_cnt == 4'(LATENCY - 1));

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CLEAR;
      CLEAR:   state_nxt = DRIVE;
      DRIVE:   if (last_vec) state_nxt = (LATENCY == 0) ? DONE : DRAIN;
      DRAIN:   if (last_drain) state_nxt = DONE;
      DONE:    if (start) state_nxt = CLEAR;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet aligned with state.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      dut_clear <= 1'b0;
      dut_input <= '0;
      signature <= '0;
      vec_count <= '0;
      seed_l    <= '0;
      step_l    <= '0;
      drain_cnt <= '0;
    end else begin
      busy      <= (state_nxt == CLEAR) || (state_nxt == DRIVE) || (state_nxt == DRAIN);
      done      <= (state_nxt == DONE);
      dut_clear <= (state_nxt == CLEAR);

      if (state_nxt == DRIVE)
        dut_input <= (state == CLEAR) ? seed_l : dut_input + step_l;
      else
        dut_input <= '0;

      if (state == DRIVE)
        vec_count <= vec_count + 8'd1;

      if ((state == DRIVE) || (state == DRAIN))
        signature <= sig_fold(signature, dut_output);

      // Only IDLE/DONE can lead to CLEAR, so this is the run-start capture point.
      if (state_nxt == CLEAR) begin
        seed_l    <= seed;
        step_l    <= step;
        signature <= '0;
        vec_count <= '0;
      end

      if (state == DRAIN) drain_cnt <= drain_cnt + 4'd1;
      else                drain_cnt <= '0;
    end
  end

`ifdef CCT_SEQ_COMPARE_EN
  assign pass = done && (signature == expected_sig);
`endif

endmodule

// File: tb/tb_cct_sequencer.sv
// Self-checking bench for cct_sequencer: a 2-deep stub circuit plus a list-based
// reference model of the input progression and rotate-XOR signature.
module tb_cct_sequencer;

  logic       clk = 1'b0;
  logic       clear_n = 1'b1;
  logic       start = 1'b0;
  logic [7:0] seed = 8'h00, step = 8'h00;
  logic       busy, done, dut_clear;
  logic [7:0] dut_input, dut_output, signature, vec_count;

  logic       start6 = 1'b0;
  logic       busy6, done6, dut_clear6;
  logic [7:0] dut_input6, signature6, vec_count6;

  logic       stub_const = 1'b0;
  logic [7:0] st1 = 8'h00, st2 = 8'h00;

`ifdef CCT_SEQ_COMPARE_EN
  logic [7:0] expected_sig = 8'h00;
  logic       pass, pass6;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // run recording
  bit         r_done, r_clr_first, r_done_first, r_pass_busy;
  int         r_busy, r_clr;
  logic [7:0] r_sig, r_vc, r_sig_at_clr;
  logic [7:0] trace[$];

  always #5 clk = ~clk;

  cct_sequencer u_dut (
    .clk(clk), .clear_n(clear_n), .start(start), .seed(seed), .step(step),
    .busy(busy), .done(done), .dut_clear(dut_clear), .dut_input(dut_input),
    .dut_output(dut_output), .signature(signature), .vec_count(vec_count)
`ifdef CCT_SEQ_COMPARE_EN
    , .expected_sig(expected_sig), .pass(pass)
`endif
  );

  cct_sequencer #(.NUM_VECTORS(6), .LATENCY(0)) u_dut6 (
    .clk(clk), .clear_n(clear_n), .start(start6), .seed(8'h00), .step(8'h00),
    .busy(busy6), .done(done6), .dut_clear(dut_clear6), .dut_input(dut_input6),
    .dut_output(8'h01), .signature(signature6), .vec_count(vec_count6)
`ifdef CCT_SEQ_COMPARE_EN
    , .expected_sig(8'h3F), .pass(pass6)
`endif
  );

  function automatic logic [7:0] g(input logic [7:0] x);
    logic [7:0] r;
    r = x * 8'd3 + 8'd1;
    return r;
  endfunction

  // Stub circuit: two-stage pipeline computing g(), synchronously cleared.
  always @(posedge clk) begin
    if (dut_clear) begin
      st1 <= 8'h00;
      st2 <= 8'h00;
    end else begin
      st1 <= g(dut_input);
      st2 <= st1;
    end
  end
  assign dut_output = stub_const ? 8'h01 : st2;

  function automatic logic [7:0] model_vec(input logic [7:0] s, input logic [7:0] st, input int k);
    logic [15:0] t;
    t = 16'(s) + 16'(k) * 16'(st);
    return t[7:0];
  endfunction

  function automatic logic [7:0] model_sig(input logic [7:0] s, input logic [7:0] st,
                                           input bit konst, input int n, input int lat);
    logic [7:0] sig, o;
    sig = 8'h00;
    for (int j = 0; j < n + lat; j++) begin
      if (konst)       o = 8'h01;
      else if (j < 2)  o = 8'h00;
      else if (j - 2 < n) o = g(model_vec(s, st, j - 2));
      else             o = g(8'h00);
      sig = {sig[6:0], sig[7]} ^ o;
    end
    return sig;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one run and record what the sequencer does until done (bounded).
  task automatic do_run(input logic [7:0] s, input logic [7:0] st, input bit hold,
                        input int pa, input int pb);
    seed = s; step = st; start = 1'b1;
    r_done = 0; r_clr_first = 0; r_done_first = 0; r_pass_busy = 0;
    r_busy = 0; r_clr = 0; r_sig_at_clr = 8'hxx;
    trace.delete();
    for (int c = 0; c < 200 && !r_done; c++) begin
      tick();
      if (c == 0) begin
        r_done_first = done;
        r_sig_at_clr = signature;
        seed = ~s;
        step = st ^ 8'h5A;
      end
      if (busy) begin
        r_busy++;
        if (dut_clear) begin
          r_clr++;
          if (r_busy == 1) r_clr_first = 1;
        end else begin
          trace.push_back(dut_input);
        end
`ifdef CCT_SEQ_COMPARE_EN
        if (pass) r_pass_busy = 1;
`endif
      end
      if (done) r_done = 1;
      start = hold || (c == pa) || (c == pb);
    end
    r_sig = signature;
    r_vc  = vec_count;
  endtask

  task automatic test_reset();
    #2 clear_n = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({busy, done, dut_clear} !== 3'b000) begin
      n_bad++; $display("FAIL reset_ctrl: got %b expected 000", {busy, done, dut_clear});
    end
    n_cmp++;
    if ({dut_input, signature, vec_count} !== 24'h0) begin
      n_bad++; $display("FAIL reset_data: got %h expected 000000", {dut_input, signature, vec_count});
    end
    clear_n = 1'b1;
    tick(); tick();
    n_cmp++;
    if ({busy, done, busy6, done6} !== 4'b0000) begin
      n_bad++; $display("FAIL idle_after_reset: got %b expected 0000", {busy, done, busy6, done6});
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp;
    stub_const = 1'b0;
    do_run(8'hF0, 8'h10, 1'b0, -1, -1);
    start = 1'b0;
    n_cmp++;
    if (r_done !== 1'b1) begin n_bad++; $display("FAIL wrap_done: got %b expected 1", r_done); end
    n_cmp++;
    if ({r_clr_first, 8'(r_clr)} !== {1'b1, 8'd1}) begin
      n_bad++; $display("FAIL wrap_clear: got first=%b cycles=%0d expected first=1 cycles=1", r_clr_first, r_clr);
    end
    n_cmp++;
    if (trace.size() !== 18) begin n_bad++; $display("FAIL wrap_len: got %0d expected 18", trace.size()); end
    for (int k = 0; k < 18 && k < trace.size(); k++) begin
      exp = (k < 16) ? model_vec(8'hF0, 8'h10, k) : 8'h00;
      n_cmp++;
      if (trace[k] !== exp) begin n_bad++; $display("FAIL wrap_vec%0d: got %h expected %h", k, trace[k], exp); end
    end
    n_cmp++;
    if (r_vc !== 8'd16) begin n_bad++; $display("FAIL wrap_vec_count: got %0d expected 16", r_vc); end
    exp = model_sig(8'hF0, 8'h10, 1'b0, 16, 2);
    n_cmp++;
    if (r_sig !== exp) begin n_bad++; $display("FAIL wrap_sig: got %h expected %h", r_sig, exp); end
  endtask

  task automatic test_signature();
    int  b6;
    bit  seen;
    stub_const = 1'b1;
    do_run(8'h12, 8'h34, 1'b0, -1, -1);
    start = 1'b0;
    n_cmp++;
    if ({r_done, r_sig} !== {1'b1, 8'h03}) begin
      n_bad++; $display("FAIL sig_const18: got done=%b sig=%h expected done=1 sig=03", r_done, r_sig);
    end
    start6 = 1'b1; b6 = 0; seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      tick();
      start6 = 1'b0;
      if (busy6) b6++;
      if (done6) seen = 1;
    end
    n_cmp++;
    if ({seen, signature6, vec_count6} !== {1'b1, 8'h3F, 8'd6}) begin
      n_bad++; $display("FAIL sig_const6: got done=%b sig=%h vc=%0d expected done=1 sig=3f vc=6", seen, signature6, vec_count6);
    end
    n_cmp++;
    if (b6 !== 7) begin n_bad++; $display("FAIL lat0_busy: got %0d expected 7", b6); end
  endtask

  task automatic test_random();
    logic [7:0] s, st, exp;
    int         bad_vec;
    stub_const = 1'b0;
    for (int r = 0; r < 4; r++) begin
      s  = 8'($urandom);
      st = 8'($urandom);
      do_run(s, st, 1'b0, -1, -1);
      start = 1'b0;
      bad_vec = 0;
      for (int k = 0; k < trace.size(); k++) begin
        exp = (k < 16) ? model_vec(s, st, k) : 8'h00;
        if (trace[k] !== exp) bad_vec++;
      end
      n_cmp++;
      if (trace.size() !== 18 || bad_vec != 0) begin
        n_bad++; $display("FAIL rand%0d_vectors: got len=%0d wrong=%0d expected len=18 wrong=0", r, trace.size(), bad_vec);
      end
      exp = model_sig(s, st, 1'b0, 16, 2);
      n_cmp++;
      if ({r_done, r_sig, r_vc} !== {1'b1, exp, 8'd16}) begin
        n_bad++; $display("FAIL rand%0d_result: got done=%b sig=%h vc=%0d expected done=1 sig=%h vc=16", r, r_done, r_sig, r_vc, exp);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int extra;
    stub_const = 1'b0;
    do_run(8'h33, 8'h11, 1'b0, 5, 17);
    start = 1'b0;
    n_cmp++;
    if ({r_done, 8'(r_busy)} !== {1'b1, 8'd19}) begin
      n_bad++; $display("FAIL busy_len: got done=%b busy=%0d expected done=1 busy=19", r_done, r_busy);
    end
    extra = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (busy || !done) extra++;
    end
    n_cmp++;
    if (extra !== 0) begin n_bad++; $display("FAIL no_restart: got %0d non-DONE cycles expected 0", extra); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    stub_const = 1'b0;
    do_run(8'h00, 8'h03, 1'b1, -1, -1);
    exp = model_sig(8'h00, 8'h03, 1'b0, 16, 2);
    n_cmp++;
    if ({r_done, r_sig} !== {1'b1, exp}) begin
      n_bad++; $display("FAIL b2b_run1: got done=%b sig=%h expected done=1 sig=%h", r_done, r_sig, exp);
    end
    do_run(8'h05, 8'h03, 1'b1, -1, -1);
    start = 1'b0;
    n_cmp++;
    if ({r_done_first, r_clr_first, r_sig_at_clr} !== {1'b0, 1'b1, 8'h00}) begin
      n_bad++; $display("FAIL b2b_restart: got done=%b clear=%b sig=%h expected done=0 clear=1 sig=00", r_done_first, r_clr_first, r_sig_at_clr);
    end
    n_cmp++;
    if (trace.size() == 0 || trace[0] !== 8'h05) begin
      n_bad++; $display("FAIL b2b_first_vec: got %h expected 05", (trace.size() == 0) ? 8'hxx : trace[0]);
    end
    exp = model_sig(8'h05, 8'h03, 1'b0, 16, 2);
    n_cmp++;
    if ({r_done, r_sig} !== {1'b1, exp}) begin
      n_bad++; $display("FAIL b2b_run2: got done=%b sig=%h expected done=1 sig=%h", r_done, r_sig, exp);
    end
    tick();
  endtask

  task automatic test_reset_mid_drive();
    int  nvec;
    bit  hit;
    stub_const = 1'b0;
    seed = 8'h21; step = 8'h04; start = 1'b1;
    nvec = 0; hit = 0;
    for (int c = 0; c < 30 && !hit; c++) begin
      tick();
      start = 1'b0;
      if (busy && !dut_clear) nvec++;
      if (nvec == 6) hit = 1;
    end
    n_cmp++;
    if ({hit, dut_input} !== {1'b1, model_vec(8'h21, 8'h04, 5)}) begin
      n_bad++; $display("FAIL mid_vec5: got reached=%b in=%h expected reached=1 in=%h", hit, dut_input, model_vec(8'h21, 8'h04, 5));
    end
    #2 clear_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, dut_input, signature, vec_count} !== 26'h0) begin
      n_bad++; $display("FAIL mid_async_reset: got busy=%b done=%b in=%h sig=%h vc=%h expected all 0", busy, done, dut_input, signature, vec_count);
    end
    @(posedge clk);
    #1 clear_n = 1'b1;
    tick(); tick();
    n_cmp++;
    if ({busy, done, dut_clear} !== 3'b000) begin
      n_bad++; $display("FAIL mid_idle: got %b expected 000", {busy, done, dut_clear});
    end
  endtask

`ifdef CCT_SEQ_COMPARE_EN
  task automatic test_compare();
    stub_const = 1'b1;
    expected_sig = 8'h03;
    do_run(8'h44, 8'h01, 1'b0, -1, -1);
    start = 1'b0;
    n_cmp++;
    if (r_pass_busy !== 1'b0) begin n_bad++; $display("FAIL pass_busy: got %b expected 0", r_pass_busy); end
    n_cmp++;
    if (pass !== 1'b1) begin n_bad++; $display("FAIL pass_match: got %b expected 1", pass); end
    expected_sig = 8'h04;
    #1;
    n_cmp++;
    if (pass !== 1'b0) begin n_bad++; $display("FAIL pass_mismatch: got %b expected 0", pass); end
  endtask
`endif

  initial begin
    test_reset();
    test_wrap();
    test_signature();
    test_random();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_drive();
`ifdef CCT_SEQ_COMPARE_EN
    test_compare();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
